uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART RX datapath. It enables and disables the receiver cleanly, so a frame already in progress is never cut off. It captures each received word and its framing-error status into a small first-word-fall-through FIFO. It keeps sticky overrun and framing-error flags and raises a level interrupt toward the APB register block.

---
 rtl/uart_rx_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: enable/drain FSM, FWFT RX FIFO of {err_tag, word}, sticky flags, level irq.
// Latency: rx_en follows enable_req by one cycle; a pushed word is visible on rd_data the next cycle.
// Backpressure: none toward the receiver; a word arriving into a full FIFO (no pop) is dropped and flagged as overrun.
//
// Ports:
//   clk, rx_rst                  clock, asynchronous active-high reset
//   enable_req -> rx_en          software enable in, registered receiver enable out
//   rx_busy, rx_done, rx_error, rx_dout   receiver status and received word
//   rd_en -> rd_data             pop request, FIFO head {err_tag, word} (0 when empty)
//   fifo_empty/full/count        FIFO occupancy
//   irq_thresh, clr_flags        level threshold (0 = off), sticky-flag clear pulse
//   overrun_flag, frame_err_flag, irq, ctrl_state   status toward the register block
module uart_rx_ctrl #(
    parameter int  DATAWIDTH  = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rx_rst,
    input  logic                 enable_req,
    output logic                 rx_en,
    input  logic                 rx_busy,
    input  logic                 rx_done,
    input  logic                 rx_error,
    input  logic [DATAWIDTH-1:0] rx_dout,
    input  logic                 rd_en,
    output logic [DATAWIDTH:0]   rd_data,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [CW-1:0]        fifo_count,
    input  logic [CW-1:0]        irq_thresh,
    input  logic                 clr_flags,
    output logic                 overrun_flag,
    output logic                 frame_err_flag,
    output logic                 irq,
    output logic [1:0]           ctrl_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;

    // rx_en is loaded with the same decision as the next state, so it is
    // high exactly while the state register holds RUN or DRAIN.
    always_ff @(posedge clk or posedge rx_rst) begin
        if (rx_rst) begin
            state <= ST_OFF;
            rx_en <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (enable_req) begin
                        state <= ST_RUN;
                        rx_en <= 1'b1;
                    end else begin
                        state <= ST_OFF;
                        rx_en <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (enable_req) begin
                        state <= ST_RUN;
                        rx_en <= 1'b1;
                    end else if (rx_busy) begin
                        // let the frame in flight finish before shutting off
                        state <= ST_DRAIN;
                        rx_en <= 1'b1;
                    end else begin
                        state <= ST_OFF;
                        rx_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // re-enable wins over completing the drain
                    if (enable_req) begin
                        state <= ST_RUN;
                        rx_en <= 1'b1;
                    end else if (rx_busy) begin
                        state <= ST_DRAIN;
                        rx_en <= 1'b1;
                    end else begin
                        state <= ST_OFF;
                        rx_en <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    rx_en <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_state = state;

    // ---------------------------------------------------------------- FIFO
    logic [DATAWIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_req;
    logic               push;
    logic               pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

    assign push_req = rx_done & rx_en;
    assign pop      = rd_en & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~fifo_full | pop);

    always_ff @(posedge clk or posedge rx_rst) begin
        if (rx_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rx_error, rx_dout};
    end

    assign rd_data = fifo_empty ? '0 : mem[rd_ptr];

    // --------------------------------------------------------- sticky flags
    logic ovr_set;
    logic ferr_set;

    assign ovr_set  = push_req & fifo_full & ~pop;
    // A bad stop bit is reported even when the word itself is dropped.
    assign ferr_set = push_req & rx_error;

    always_ff @(posedge clk or posedge rx_rst) begin
        if (rx_rst) begin
            overrun_flag   <= 1'b0;
            frame_err_flag <= 1'b0;
        end else begin
            if (ovr_set)        overrun_flag <= 1'b1;
            else if (clr_flags) overrun_flag <= 1'b0;
            if (ferr_set)       frame_err_flag <= 1'b1;
            else if (clr_flags) frame_err_flag <= 1'b0;
        end
    end

    // irq_thresh is static configuration; the event terms are all registered.
    assign irq = ((irq_thresh != '0) && (fifo_count >= irq_thresh))
               | overrun_flag | frame_err_flag;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rx_rst;
    logic          enable_req;
    logic          rx_en;
    logic          rx_busy;
    logic          rx_done;
    logic          rx_error;
    logic [DW-1:0] rx_dout;
    logic          rd_en;
    logic [DW:0]   rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] irq_thresh;
    logic          clr_flags;
    logic          overrun_flag;
    logic          frame_err_flag;
    logic          irq;
    logic [1:0]    ctrl_state;

    uart_rx_ctrl #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rx_rst         (rx_rst),
        .enable_req     (enable_req),
        .rx_en          (rx_en),
        .rx_busy        (rx_busy),
        .rx_done        (rx_done),
        .rx_error       (rx_error),
        .rx_dout        (rx_dout),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .irq_thresh     (irq_thresh),
        .clr_flags      (clr_flags),
        .overrun_flag   (overrun_flag),
        .frame_err_flag (frame_err_flag),
        .irq            (irq),
        .ctrl_state     (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rx_rst && rd_en && !fifo_empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no entry", rd_data);
            end else begin
                chk("pop_data", 16'(rd_data), 16'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rx_done; the expected entry is queued only if it should be stored.
    task automatic do_push(input logic [DW-1:0] d, input logic e, input bit acc);
        rx_done  = 1'b1;
        rx_dout  = d;
        rx_error = e;
        if (acc) exp_q.push_back({e, d});
        tick();
        rx_done  = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic do_pop(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_rst     = 1'b1;
        enable_req = 1'b0;
        rx_busy    = 1'b0;
        rx_done    = 1'b0;
        rx_error   = 1'b0;
        rx_dout    = '0;
        rd_en      = 1'b0;
        irq_thresh = '0;
        clr_flags  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_en", 16'(rx_en), 16'h0);
        chk("rst_state", 16'(ctrl_state), 16'h0);
        chk("rst_empty", 16'(fifo_empty), 16'h1);
        chk("rst_full", 16'(fifo_full), 16'h0);
        chk("rst_count", 16'(fifo_count), 16'h0);
        chk("rst_rd_data", 16'(rd_data), 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        rx_rst = 1'b0;
        tick();

        // 1: enable, three clean frames, read back in order
        enable_req = 1'b1;
        tick();
        chk("t1_state_run", 16'(ctrl_state), 16'h1);
        chk("t1_rx_en", 16'(rx_en), 16'h1);
        rx_busy = 1'b1;
        do_push(8'h41, 1'b0, 1'b1);
        do_push(8'h42, 1'b0, 1'b1);
        do_push(8'h43, 1'b0, 1'b1);
        rx_busy = 1'b0;
        chk("t1_count", 16'(fifo_count), 16'h3);
        chk("t1_head", 16'(rd_data), 16'h041);
        do_pop(3);
        chk("t1_empty", 16'(fifo_empty), 16'h1);
        do_pop(1);   // pop on empty is ignored
        chk("t1_empty_pop_count", 16'(fifo_count), 16'h0);

        // 2: overflow
        do_push(8'h10, 1'b0, 1'b1);
        do_push(8'h11, 1'b0, 1'b1);
        do_push(8'h12, 1'b0, 1'b1);
        do_push(8'h13, 1'b0, 1'b1);
        do_push(8'h14, 1'b0, 1'b0);
        chk("t2_full", 16'(fifo_full), 16'h1);
        chk("t2_count", 16'(fifo_count), 16'h4);
        chk("t2_overrun", 16'(overrun_flag), 16'h1);
        chk("t2_frame_err", 16'(frame_err_flag), 16'h0);
        chk("t2_irq", 16'(irq), 16'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t2_overrun_clr", 16'(overrun_flag), 16'h0);
        chk("t2_irq_clr", 16'(irq), 16'h0);

        // 3: full FIFO, push and pop in the same cycle
        rd_en = 1'b1;
        do_push(8'h55, 1'b0, 1'b1);
        rd_en = 1'b0;
        chk("t3_count", 16'(fifo_count), 16'h4);
        chk("t3_overrun", 16'(overrun_flag), 16'h0);
        do_pop(4);   // 0x11, 0x12, 0x13, 0x055
        chk("t3_empty", 16'(fifo_empty), 16'h1);

        // 4: framing errors and clear/set collision
        do_push(8'hA5, 1'b1, 1'b1);
        chk("t4_head", 16'(rd_data), 16'h1A5);
        chk("t4_ferr", 16'(frame_err_flag), 16'h1);
        chk("t4_irq", 16'(irq), 16'h1);
        clr_flags = 1'b1;
        do_push(8'h3C, 1'b1, 1'b1);
        clr_flags = 1'b0;
        chk("t4_ferr_set_wins", 16'(frame_err_flag), 16'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("t4_ferr_clr", 16'(frame_err_flag), 16'h0);
        do_pop(2);   // 0x1A5, 0x13C

        // 5: disable mid-frame drains, then turns off
        rx_busy    = 1'b1;
        enable_req = 1'b0;
        tick();
        chk("t5_state_drain", 16'(ctrl_state), 16'h2);
        chk("t5_rx_en_drain", 16'(rx_en), 16'h1);
        do_push(8'h77, 1'b0, 1'b1);
        chk("t5_count", 16'(fifo_count), 16'h1);
        rx_busy = 1'b0;
        tick();
        chk("t5_state_off", 16'(ctrl_state), 16'h0);
        chk("t5_rx_en_off", 16'(rx_en), 16'h0);
        do_push(8'h99, 1'b0, 1'b0);   // ignored while disabled
        chk("t5_off_ignored", 16'(fifo_count), 16'h1);
        chk("t5_off_head", 16'(rd_data), 16'h077);
        do_pop(1);

        // 6: level interrupt, then asynchronous reset mid-frame
        irq_thresh = CW'(2);
        enable_req = 1'b1;
        tick();
        do_push(8'h01, 1'b0, 1'b1);
        chk("t6_irq_lvl1", 16'(irq), 16'h0);
        do_push(8'h02, 1'b0, 1'b1);
        chk("t6_irq_lvl2", 16'(irq), 16'h1);
        rx_busy = 1'b1;
        tick();
        #2;
        rx_rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t6_arst_state", 16'(ctrl_state), 16'h0);
        chk("t6_arst_rx_en", 16'(rx_en), 16'h0);
        chk("t6_arst_count", 16'(fifo_count), 16'h0);
        chk("t6_arst_empty", 16'(fifo_empty), 16'h1);
        chk("t6_arst_rd_data", 16'(rd_data), 16'h0);
        chk("t6_arst_irq", 16'(irq), 16'h0);
        enable_req = 1'b0;
        rx_busy    = 1'b0;
        tick();
        rx_rst = 1'b0;
        tick();

        chk("sb_drained", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
